request_decoder: RTL and testbench
==================================

# request_decoder

Parametrised successor to the two-byte request decoder between the UART receiver and the sensor devices. Consumes the byte stream (request code, then device address) and registers the request code. Decodes the address against a configurable base into a one-hot selector over NUM_DEVICES channels. Adds a command-valid strobe, out-of-range address flagging and an optional inter-byte timeout that resynchronises the protocol after a lost byte.

## Interface
- DATA_WIDTH, 8: width of received bytes, request and address registers.
- NUM_DEVICES, 32: number of selectable devices; selector width. Range 1..2^DATA_WIDTH.
- BASE_ADDRESS, 8'h20: address mapped to device_selector[0].
- TIMEOUT_CYCLES, 50_000_000: maximum cycles allowed between request byte and address byte. Used only with REQUEST_TIMEOUT_EN.

Ports:
- clock  in  1  system clock. Single clock domain.
- reset  in  1  synchronous, active-high reset.
- has_request  in  1  one-cycle strobe; received_data is valid.
- received_data  in  DATA_WIDTH  byte from the UART receiver.
- request  out  DATA_WIDTH  latched request code.
- address  out  DATA_WIDTH  latched device address.
- device_selector  out  NUM_DEVICES  one-hot selected device, or all zero.
- command_valid  out  1  one-cycle pulse when a command is decoded.
- address_error  out  1  level; last decoded address was out of range.
- timeout  out  1  one-cycle pulse when a command is aborted by the timeout.
- busy  out  1  high in WAIT_ADDRESS and DECODE.

## Operation
- States: WAIT_REQUEST, WAIT_ADDRESS, DECODE. Reset state is WAIT_REQUEST.
- WAIT_REQUEST, on has_request:
  - load request with received_data;
  - clear device_selector and address_error;
  - go to WAIT_ADDRESS.
- WAIT_ADDRESS, on has_request: load address with received_data; go to DECODE.
- DECODE, unconditional single cycle:
  - offset = address - BASE_ADDRESS, computed DATA_WIDTH+1 bits wide; negative is out of range.
  - If 0 <= offset < NUM_DEVICES: device_selector[offset] = 1, all other bits 0, address_error = 0.
  - Otherwise: device_selector = 0, address_error = 1.
  - command_valid pulses in both cases. Go to WAIT_REQUEST.
- A has_request strobe arriving during DECODE counts as the request byte of the next command:
  - request is loaded;
  - the decode of the current command still completes;
  - the next state is WAIT_ADDRESS.
  - device_selector is not cleared in this case; it shows the current decode.
- device_selector, address_error, request and address hold their values until overwritten as above.
- Reset values: request = 0, address = 0, device_selector = 0, command_valid = 0, address_error = 0, timeout = 0, busy = 0.

## Timing
- Latency: address byte strobe in cycle N; device_selector, address_error and command_valid are visible in cycle N+2 (one cycle in DECODE).
- command_valid and timeout are exactly one cycle wide.
- Back-to-back bytes on consecutive cycles are accepted; no strobe is dropped.
- Reset asserted mid-command: next cycle is WAIT_REQUEST with all outputs at reset values. The partial command is discarded.
- Timeout (when compiled in):
  - counter clears when the request byte is accepted and increments each cycle in WAIT_ADDRESS;
  - on reaching TIMEOUT_CYCLES without an address byte: state becomes WAIT_REQUEST, timeout pulses, device_selector is cleared;
  - an address byte in the expiry cycle wins; no timeout.

## Configuration
- REQUEST_TIMEOUT_EN defined: timeout counter, timeout pulse and abort behaviour are present.
- Not defined: WAIT_ADDRESS waits indefinitely, timeout is tied to 0, no counter is synthesised.

## Structure
- Shared package request_decoder_pkg holds:
  - state encoding constants (WAIT_REQUEST, WAIT_ADDRESS, DECODE);
  - default BASE_ADDRESS;
  - default NUM_DEVICES.
- Sub-module request_timer holds the $clog2(TIMEOUT_CYCLES+1)-bit counter with clear/enable inputs and an expired output. It is instantiated only under REQUEST_TIMEOUT_EN.

## Test plan
- Reset, then bytes 8'h01 and 8'h20 with one idle cycle between -> request = 8'h01, device_selector = 32'h0000_0001, command_valid pulses 2 cycles after the 8'h20 strobe, address_error = 0.
- Bytes 8'h03 and 8'h3F -> device_selector = 32'h8000_0000. Then bytes 8'h03 and 8'h40 -> device_selector = 0, address_error = 1. Then bytes 8'h03 and 8'h1F -> same error response.
- Bytes 8'h01, 8'h21, 8'h02, 8'h22 on four consecutive cycles -> two command_valid pulses; selectors 32'h2 then 32'h4; final request = 8'h02.
- REQUEST_TIMEOUT_EN with TIMEOUT_CYCLES = 16: byte 8'h01, no address byte -> timeout pulses after 16 cycles, busy = 0. The next bytes 8'h05, 8'h20 decode normally.
- Reset asserted during WAIT_ADDRESS after byte 8'h07 -> all outputs 0 the next cycle. Then bytes 8'h01, 8'h20 -> selector bit 0.
- NUM_DEVICES = 4, BASE_ADDRESS = 8'h10: address 8'h13 -> selector 4'b1000; address 8'h14 -> address_error = 1.

Source files
------------

// File: rtl/request_decoder_pkg.sv
// Shared definitions for the request decoder: FSM state encoding and
// default decode parameters.
package request_decoder_pkg;

    typedef enum logic [1:0] {
        WAIT_REQUEST = 2'd0,
        WAIT_ADDRESS = 2'd1,
        DECODE       = 2'd2
    } state_t;

    localparam int         DEFAULT_NUM_DEVICES  = 32;
    localparam logic [7:0] DEFAULT_BASE_ADDRESS = 8'h20;

endpackage

// File: rtl/request_decoder_if.sv
// Byte-stream input and decoded-command outputs of the request decoder.
// The master side is the UART/consumer side; the slave side is the decoder.
interface request_decoder_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_DEVICES = 32
);
    logic                   has_request;
    logic [DATA_WIDTH-1:0]  received_data;
    logic [DATA_WIDTH-1:0]  request;
    logic [DATA_WIDTH-1:0]  address;
    logic [NUM_DEVICES-1:0] device_selector;
    logic                   command_valid;
    logic                   address_error;
    logic                   timeout;
    logic                   busy;

    modport master (
        output has_request, received_data,
        input  request, address, device_selector, command_valid,
               address_error, timeout, busy
    );

    modport slave (
        input  has_request, received_data,
        output request, address, device_selector, command_valid,
               address_error, timeout, busy
    );
endinterface

// File: rtl/request_timer.sv
// Saturating inter-byte timer: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT_CYCLES enabled cycles have elapsed.
module request_timer #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int            COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);

    logic [COUNT_WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + COUNT_WIDTH'(1);
        end
    end

    assign expired = enable && (count == LIMIT);
endmodule

// File: rtl/request_decoder.sv
// Two-byte request decoder: latches request code and device address, then
// decodes the address into a one-hot device selector. Define
// REQUEST_TIMEOUT_EN to add the inter-byte timeout that resynchronises.
module request_decoder
    import request_decoder_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    NUM_DEVICES    = DEFAULT_NUM_DEVICES,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS   = DATA_WIDTH'(DEFAULT_BASE_ADDRESS),
    parameter int                    TIMEOUT_CYCLES = 50_000_000
) (
    input logic              clock,
    input logic              reset,
    request_decoder_if.slave bus
);
    localparam logic [DATA_WIDTH:0] DEVICE_LIMIT = (DATA_WIDTH + 1)'(NUM_DEVICES);

    if (NUM_DEVICES < 1 || NUM_DEVICES > (1 << DATA_WIDTH) || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("request_decoder: illegal parameter combination");
    end

    state_t state, state_next;
    logic   load_request, load_address, decode, clear_selection, abort;
    logic   expired;

    logic [DATA_WIDTH:0]    offset;
    logic                   in_range;
    logic [NUM_DEVICES-1:0] one_hot;

    // One bit wider than the address so an address below the base goes negative.
    assign offset   = {1'b0, bus.address} - {1'b0, BASE_ADDRESS};
    assign in_range = !offset[DATA_WIDTH] && (offset < DEVICE_LIMIT);
    assign one_hot  = NUM_DEVICES'(1) << offset[DATA_WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= WAIT_REQUEST;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_next      = state;
        load_request    = 1'b0;
        load_address    = 1'b0;
        decode          = 1'b0;
        clear_selection = 1'b0;
        abort           = 1'b0;
        unique case (state)
            WAIT_REQUEST: begin
                if (bus.has_request) begin
                    load_request    = 1'b1;
                    clear_selection = 1'b1;
                    state_next      = WAIT_ADDRESS;
                end
            end
            WAIT_ADDRESS: begin
                // An address byte in the expiry cycle takes priority over the abort.
                if (bus.has_request) begin
                    load_address = 1'b1;
                    state_next   = DECODE;
                end else if (expired) begin
                    abort      = 1'b1;
                    state_next = WAIT_REQUEST;
                end
            end
            DECODE: begin
                decode     = 1'b1;
                state_next = WAIT_REQUEST;
                if (bus.has_request) begin
                    load_request = 1'b1;
                    state_next   = WAIT_ADDRESS;
                end
            end
            default: state_next = WAIT_REQUEST;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register updates from the
        // values present before the clock edge.
        if (reset) begin
            bus.request         <= '0;
            bus.address         <= '0;
            bus.device_selector <= '0;
            bus.command_valid   <= 1'b0;
            bus.address_error   <= 1'b0;
        end else begin
            bus.command_valid <= decode;
            if (load_request) begin
                bus.request <= bus.received_data;
            end
            if (load_address) begin
                bus.address <= bus.received_data;
            end
            if (clear_selection || abort) begin
                bus.device_selector <= '0;
            end
            if (clear_selection) begin
                bus.address_error <= 1'b0;
            end
            if (decode) begin
                bus.device_selector <= in_range ? one_hot : '0;
                bus.address_error   <= !in_range;
            end
        end
    end

    assign bus.busy = (state != WAIT_REQUEST);

`ifdef REQUEST_TIMEOUT_EN
    request_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (load_request),
        .enable (state == WAIT_ADDRESS),
        .expired(expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.timeout <= 1'b0;
        end else begin
            bus.timeout <= abort;
        end
    end
`else
    assign expired     = 1'b0;
    assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_request_decoder.sv
// Self-checking bench for request_decoder: two instances (32 devices at 0x20,
// 4 devices at 0x10) share one byte stream and are compared to a command model.
module tb_request_decoder;

`ifdef REQUEST_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int TO    = 16;
`else
    localparam bit TO_EN = 1'b0;
    localparam int TO    = 50_000_000;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    request_decoder_if #(.DATA_WIDTH(8), .NUM_DEVICES(32)) bus_main ();
    request_decoder_if #(.DATA_WIDTH(8), .NUM_DEVICES(4))  bus_small ();

    request_decoder #(
        .DATA_WIDTH(8), .NUM_DEVICES(32), .BASE_ADDRESS(8'h20), .TIMEOUT_CYCLES(TO)
    ) dut_main (
        .clock(clock), .reset(reset), .bus(bus_main)
    );

    request_decoder #(
        .DATA_WIDTH(8), .NUM_DEVICES(4), .BASE_ADDRESS(8'h10), .TIMEOUT_CYCLES(TO)
    ) dut_small (
        .clock(clock), .reset(reset), .bus(bus_small)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Command-level view: have_req = request byte taken, address outstanding;
    // pend = address byte taken, decode result due at the next edge.
    typedef struct {
        logic [7:0]  request;
        logic [7:0]  address;
        logic [31:0] sel;
        bit          err;
        bit          cv;
        bit          to;
        bit          have_req;
        bit          pend;
        int          waited;
    } model_t;

    model_t m_main, m_small;

    function automatic model_t model_step(model_t m, bit rst, bit hr, logic [7:0] d,
                                          int n, int base);
        model_t r = m;
        bit     finishing;
        int     off;
        r.cv = 1'b0;
        r.to = 1'b0;
        if (rst) begin
            r = '{default: 0};
            return r;
        end
        finishing = r.pend;
        if (finishing) begin
            off = int'(r.address) - base;
            if (off >= 0 && off < n) begin
                r.sel = 32'd1 << off;
                r.err = 1'b0;
            end else begin
                r.sel = '0;
                r.err = 1'b1;
            end
            r.cv   = 1'b1;
            r.pend = 1'b0;
        end
        if (hr) begin
            if (!r.have_req) begin
                r.request  = d;
                r.have_req = 1'b1;
                r.waited   = 0;
                if (!finishing) begin
                    r.sel = '0;
                    r.err = 1'b0;
                end
            end else begin
                r.address  = d;
                r.have_req = 1'b0;
                r.pend     = 1'b1;
            end
        end else if (r.have_req) begin
            if (TO_EN && r.waited == TO) begin
                r.have_req = 1'b0;
                r.sel      = '0;
                r.to       = 1'b1;
            end else begin
                r.waited++;
            end
        end
        return r;
    endfunction

    task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic compare_all();
        check("main.request",   32'(bus_main.request),         32'(m_main.request));
        check("main.address",   32'(bus_main.address),         32'(m_main.address));
        check("main.selector",  bus_main.device_selector,      m_main.sel);
        check("main.cmd_valid", 32'(bus_main.command_valid),   32'(m_main.cv));
        check("main.addr_err",  32'(bus_main.address_error),   32'(m_main.err));
        check("main.timeout",   32'(bus_main.timeout),         32'(m_main.to));
        check("main.busy",      32'(bus_main.busy),            32'(m_main.have_req || m_main.pend));
        check("small.request",  32'(bus_small.request),        32'(m_small.request));
        check("small.address",  32'(bus_small.address),        32'(m_small.address));
        check("small.selector", 32'(bus_small.device_selector), m_small.sel);
        check("small.cmd_valid", 32'(bus_small.command_valid), 32'(m_small.cv));
        check("small.addr_err", 32'(bus_small.address_error),  32'(m_small.err));
        check("small.timeout",  32'(bus_small.timeout),        32'(m_small.to));
        check("small.busy",     32'(bus_small.busy),           32'(m_small.have_req || m_small.pend));
    endtask

    // One clock cycle: drive inputs, let the edge sample them, then compare.
    task automatic step(bit rst, bit hr, logic [7:0] d);
        reset                   = rst;
        bus_main.has_request    = hr;
        bus_main.received_data  = d;
        bus_small.has_request   = hr;
        bus_small.received_data = d;
        @(posedge clock);
        #1;
        m_main  = model_step(m_main,  rst, hr, d, 32, 'h20);
        m_small = model_step(m_small, rst, hr, d, 4,  'h10);
        compare_all();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic timeout_tests();
        int seen;
        seen = -1;
        step(1'b0, 1'b1, 8'h01);
`ifdef REQUEST_TIMEOUT_EN
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (bus_main.timeout && seen < 0) seen = i;
        end
        check("lit.timeout_cycle", 32'(seen), 32'd17);
        check("lit.timeout_busy",  32'(bus_main.busy), 32'd0);
        step(1'b0, 1'b1, 8'h05);
        idle(16);
        step(1'b0, 1'b1, 8'h20);
        step(1'b0, 1'b0, 8'h00);
        check("lit.expiry_addr_wins_cv", 32'(bus_main.command_valid), 32'd1);
        check("lit.expiry_addr_wins_sel", bus_main.device_selector, 32'h1);
        check("lit.expiry_request", 32'(bus_main.request), 32'h05);
`else
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (bus_main.timeout && seen < 0) seen = i;
        end
        check("lit.no_timeout", 32'(seen), 32'hffff_ffff);
        check("lit.still_busy", 32'(bus_main.busy), 32'd1);
        step(1'b0, 1'b1, 8'h20);
        step(1'b0, 1'b0, 8'h00);
        check("lit.late_addr_cv", 32'(bus_main.command_valid), 32'd1);
        check("lit.late_addr_sel", bus_main.device_selector, 32'h1);
`endif
    endtask

    initial begin
        m_main  = '{default: 0};
        m_small = '{default: 0};
        bus_main.has_request    = 1'b0;
        bus_main.received_data  = '0;
        bus_small.has_request   = 1'b0;
        bus_small.received_data = '0;

        repeat (3) step(1'b1, 1'b0, 8'h00);
        check("lit.reset_request", 32'(bus_main.request), 32'd0);
        check("lit.reset_selector", bus_main.device_selector, 32'd0);
        check("lit.reset_busy", 32'(bus_main.busy), 32'd0);

        // Request, idle cycle, address at base.
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h20);
        check("lit.decode_cycle_cv", 32'(bus_main.command_valid), 32'd0);
        step(1'b0, 1'b0, 8'h00);
        check("lit.first_cv", 32'(bus_main.command_valid), 32'd1);
        check("lit.first_sel", bus_main.device_selector, 32'h0000_0001);
        check("lit.first_request", 32'(bus_main.request), 32'h01);
        check("lit.first_err", 32'(bus_main.address_error), 32'd0);
        step(1'b0, 1'b0, 8'h00);
        check("lit.cv_one_cycle", 32'(bus_main.command_valid), 32'd0);

        // Top device, just above range, just below base.
        step(1'b0, 1'b1, 8'h03); step(1'b0, 1'b1, 8'h3F); step(1'b0, 1'b0, 8'h00);
        check("lit.top_sel", bus_main.device_selector, 32'h8000_0000);
        step(1'b0, 1'b1, 8'h03); step(1'b0, 1'b1, 8'h40); step(1'b0, 1'b0, 8'h00);
        check("lit.above_sel", bus_main.device_selector, 32'h0);
        check("lit.above_err", 32'(bus_main.address_error), 32'd1);
        step(1'b0, 1'b1, 8'h03); step(1'b0, 1'b1, 8'h1F); step(1'b0, 1'b0, 8'h00);
        check("lit.below_err", 32'(bus_main.address_error), 32'd1);

        // Back-to-back commands on consecutive cycles.
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h21);
        step(1'b0, 1'b1, 8'h02);
        check("lit.b2b_sel1", bus_main.device_selector, 32'h2);
        check("lit.b2b_cv1", 32'(bus_main.command_valid), 32'd1);
        step(1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b0, 8'h00);
        check("lit.b2b_sel2", bus_main.device_selector, 32'h4);
        check("lit.b2b_request", 32'(bus_main.request), 32'h02);

        // Small instance boundaries.
        step(1'b0, 1'b1, 8'h01); step(1'b0, 1'b1, 8'h13); step(1'b0, 1'b0, 8'h00);
        check("lit.small_top_sel", 32'(bus_small.device_selector), 32'h8);
        step(1'b0, 1'b1, 8'h01); step(1'b0, 1'b1, 8'h14); step(1'b0, 1'b0, 8'h00);
        check("lit.small_above_err", 32'(bus_small.address_error), 32'd1);

        timeout_tests();
        idle(2);

        // Reset in the middle of a command.
        step(1'b0, 1'b1, 8'h07);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check("lit.midreset_request", 32'(bus_main.request), 32'd0);
        check("lit.midreset_busy", 32'(bus_main.busy), 32'd0);
        step(1'b0, 1'b1, 8'h01); step(1'b0, 1'b1, 8'h20); step(1'b0, 1'b0, 8'h00);
        check("lit.after_reset_sel", bus_main.device_selector, 32'h1);

        // Randomized stream biased toward both decode windows.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            bit         hr;
            bit         rst;
            case ($urandom_range(0, 2))
                0:       d = 8'($urandom_range(0, 255));
                1:       d = 8'($urandom_range(8'h1C, 8'h44));
                default: d = 8'($urandom_range(8'h0C, 8'h16));
            endcase
            hr  = ($urandom_range(0, 99) < 45);
            rst = ($urandom_range(0, 199) == 0);
            step(rst, hr, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
